// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin PUSH/POP/GET arbiter for a shared 5-entry stack with occupancy guarding
`timescale 1ns/1ps
module stack_arbiter #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 5,
  parameter int IDX_W  = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [1:0]            REQ_VALID,
  input  logic [3:0]            REQ_CMD,
  input  logic [2*DATA_W-1:0]   REQ_DATA,
  input  logic [2*IDX_W-1:0]    REQ_INDEX,
  output logic [1:0]            REQ_DONE,
  output logic [DATA_W-1:0]     RSP_DATA,
  output logic                  RSP_ERR,
  output logic [2:0]            COUNT,
  output logic [1:0]            STK_CMD,
  output logic [IDX_W-1:0]      STK_INDEX,
  inout  wire  [DATA_W-1:0]     STK_IO
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP, GAP} state_t;
  localparam logic [1:0] NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, GET = 2'b11;
  state_t state_q, state_d;
  logic last_q, last_d, err_q, err_d, drv_q, drv_d;
  logic [1:0] cmd_q, cmd_d, done_q, done_d, stk_cmd_q, stk_cmd_d;
  logic [DATA_W-1:0] data_q, data_d, rd_q, rd_d;
  logic [IDX_W-1:0] stk_idx_q, stk_idx_d;
  logic [2:0] count_q, count_d;
  logic gnt, ok, rd_op;
  logic [1:0] g_cmd;
  logic [DATA_W-1:0] g_data;
  logic [IDX_W-1:0] g_idx;
  // Grant selection, legality against the current occupancy, and next-state sequencing
  always_comb begin
    gnt = &REQ_VALID ? ~last_q : REQ_VALID[1];
    g_cmd = gnt ? REQ_CMD[3:2] : REQ_CMD[1:0];
    g_data = gnt ? REQ_DATA[2*DATA_W-1:DATA_W] : REQ_DATA[DATA_W-1:0];
    g_idx = gnt ? REQ_INDEX[2*IDX_W-1:IDX_W] : REQ_INDEX[IDX_W-1:0];
    ok = g_cmd == PUSH ? count_q < 3'(DEPTH) :
         g_cmd == POP  ? count_q != 3'd0 :
         g_cmd == GET  ? 3'(g_idx) < count_q : 1'b1;
    state_d = state_q;
    last_d = last_q;
    cmd_d = cmd_q;
    data_d = data_q;
    err_d = err_q;
    drv_d = drv_q;
    done_d = done_q;
    stk_cmd_d = stk_cmd_q;
    stk_idx_d = stk_idx_q;
    count_d = count_q;
    case (state_q)
      IDLE: if (|REQ_VALID) begin
        last_d = gnt;
        cmd_d = g_cmd;
        data_d = g_data;
        if (ok && g_cmd != NOP) begin
          state_d = ISSUE;
          stk_cmd_d = g_cmd;
          stk_idx_d = g_idx;
          drv_d = g_cmd == PUSH;
        end else begin
          state_d = RESP;
          err_d = ~ok;
          done_d = gnt ? 2'b10 : 2'b01;
        end
      end
      ISSUE: begin
        state_d = RESP;
        stk_cmd_d = NOP;
        stk_idx_d = '0;
        drv_d = 1'b0;
        done_d = last_q ? 2'b10 : 2'b01;
        count_d = count_q + 3'(cmd_q == PUSH) - 3'(cmd_q == POP);
      end
      RESP: begin
        state_d = GAP;
        done_d = 2'b00;
        err_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // Control state and registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      cmd_q <= NOP;
      data_q <= '0;
      err_q <= 1'b0;
      drv_q <= 1'b0;
      done_q <= 2'b00;
      stk_cmd_q <= NOP;
      stk_idx_q <= '0;
      count_q <= 3'd0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cmd_q <= cmd_d;
      data_q <= data_d;
      err_q <= err_d;
      drv_q <= drv_d;
      done_q <= done_d;
      stk_cmd_q <= stk_cmd_d;
      stk_idx_q <= stk_idx_d;
      count_q <= count_d;
    end
  end
  assign rd_op = cmd_q[1] && !err_q;
  // Read data is only valid on the bus during the high phase of RESP
  always_comb rd_d = (state_q == RESP && rd_op) ? STK_IO : rd_q;
  // Capture the stack's read word as it releases the bus
  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) rd_q <= '0;
    else rd_q <= rd_d;
  end
  assign REQ_DONE = done_q;
  assign RSP_ERR = err_q;
  assign COUNT = count_q;
  assign STK_CMD = stk_cmd_q;
  assign STK_INDEX = stk_idx_q;
  assign STK_IO = drv_q ? data_q : 'z;
  assign RSP_DATA = (state_q == RESP && rd_op) ? rd_q : '0;
endmodule
